pwm_multi: RTL
==============

PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 Parameter NCH, default 4, number of PWM channels (legal 1..8).
REQ-002 Parameter CW, default 16, counter/period/duty width in bits (legal 8..32).
REQ-003 clk  input  1  single clock; all state on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 address  input  8  byte address of register access.
REQ-006 write_data  input  32  write data.
REQ-007 read_data  output  32  read data, combinational from address.
REQ-008 we  input  1  write strobe, one access per cycle.
REQ-009 re  input  1  read strobe; reads have no side effects.
REQ-010 pwm_out  output  NCH  registered PWM outputs.
REQ-011 irq  output  1  level interrupt = STATUS.wrap AND CTRL.irqen.

Function
REQ-012 Register map SHALL be: 0x00 PERIOD, 0x04 CTRL, 0x08 COUNTER, 0x0C STATUS, 0x10 CHEN, 0x14 POL, 0x20+4*i DUTY[i] for i<NCH; other addresses read 0, writes ignored.
REQ-013 CTRL bits SHALL be: [0] enable, [1] center mode, [2] irqen, [31:16] prescale; other bits read 0.
REQ-014 PERIOD/DUTY writes SHALL take low CW bits into shadow registers; reads return shadow, zero-extended.
REQ-015 Active period/duty SHALL load from shadow at each update event, and every cycle while CTRL.enable=0.
REQ-016 Prescaler SHALL produce a tick when pre_count=0 (reloaded with prescale), else decrement; runs only while enabled; unrelated register writes do not stall it.
REQ-017 Edge mode: on tick, counter increments; at counter >= active_period-1 it wraps to 0 (update event).
REQ-018 Center mode: counter counts up to active_period-1, then down to 0, then up; reaching 0 while counting down is the update event.
REQ-019 Active period 0 or 1 SHALL hold counter at 0 with an update event on every tick.
REQ-020 Channel raw level SHALL be (counter < active_duty[i]); duty 0 gives constant 0, duty >= period constant 1.
REQ-021 pwm_out[i] SHALL be registered: (enable AND CHEN[i] ? raw : 0) XOR POL[i], one cycle after counter.
REQ-022 Write to COUNTER (any data) SHALL clear counter, set direction up, reload pre_count.
REQ-023 Write to CTRL SHALL reload pre_count with new prescale field.
REQ-024 Update event SHALL set STATUS[0] (wrap); writing STATUS with bit0=1 clears it; simultaneous set and clear: set wins.
REQ-025 Clearing CTRL.enable SHALL freeze counter, direction and pre_count.

Reset
REQ-026 Reset values: shadow/active PERIOD 1000, all DUTY 500, CTRL 0x00010000, CHEN 0, POL 0, STATUS 0.
REQ-027 Reset values: counter 0, direction up, pre_count 0, pwm_out 0, irq 0; reset mid-period aborts immediately.

Structure
REQ-028 Shared package pwm_multi_pkg SHALL hold register address constants and CTRL bit/field positions.
REQ-029 Sub-module pwm_multi_ch SHALL implement one channel (active duty, compare, polarity, output register), generated NCH times.

Verification
REQ-030 Prescale 0, PERIOD 10, DUTY0 3, CHEN 1, enable edge -> pwm_out[0] high 3 of every 10 cycles.
REQ-031 Center mode, prescale 0, PERIOD 4, DUTY0 2 -> counter 0,1,2,3,2,1,0,...; pwm_out[0] high 3 of every 6 cycles.
REQ-032 Prescale 2, PERIOD 5 -> counter advances every 3 cycles, wraps every 15 cycles.
REQ-033 Edge PERIOD 10, write DUTY0 7 at counter 4 -> high time stays 3 until wrap, then 7.
REQ-034 irqen=1 -> irq rises on wrap; STATUS write 0x1 clears it; clear on wrap cycle leaves irq 1.
REQ-035 POL0=1, enable 0 -> pwm_out[0]=1; rst_n low mid-period -> pwm_out=0, counter 0, CTRL reads 0x00010000.

Source files
------------

// File: rtl/pwm_multi_pkg.sv
// pwm_multi shared definitions
// register map, CTRL layout, reset values
package pwm_multi_pkg;

  localparam logic [7:0] ADDR_PERIOD  = 8'h00;
  localparam logic [7:0] ADDR_CTRL    = 8'h04;
  localparam logic [7:0] ADDR_COUNTER = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h0C;
  localparam logic [7:0] ADDR_CHEN    = 8'h10;
  localparam logic [7:0] ADDR_POL     = 8'h14;
  localparam logic [7:0] ADDR_DUTY    = 8'h20;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_CENTER  = 1;
  localparam int CTRL_IRQEN   = 2;
  localparam int CTRL_PRE_LSB = 16;
  localparam int CTRL_PRE_MSB = 31;

  localparam int          RST_PERIOD   = 1000;
  localparam int          RST_DUTY     = 500;
  localparam logic [15:0] RST_PRESCALE = 16'd1;

  typedef struct packed {
    logic [15:0] prescale;
    logic        irqen;
    logic        center;
    logic        enable;
  } ctrl_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  function automatic logic [31:0] ctrl_word(ctrl_t c);
    return {c.prescale, 13'b0, c.irqen, c.center, c.enable};
  endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// pwm_multi register bus
// single-cycle write strobe, combinational read
interface pwm_multi_if;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        we;
  logic        re;

  modport master (
    output address, write_data, we, re,
    input  read_data
  );

  modport slave (
    input  address, write_data, we, re,
    output read_data
  );
endinterface

// File: rtl/pwm_multi_ch.sv
// pwm_multi single channel
// active duty, compare, polarity, output flop
module pwm_multi_ch
  import pwm_multi_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] duty_sh,
  input  logic [CW-1:0] counter,
  input  logic          en,
  input  logic          pol,
  output logic          pwm
);

  logic [CW-1:0] duty_act;
  logic          raw;

  assign raw = counter < duty_act;

  // active duty follows shadow at update, output registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_act <= CW'(RST_DUTY);
      pwm      <= 1'b0;
    end else begin
      if (load)
        duty_act <= duty_sh;
      pwm <= (en & raw) ^ pol;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi top
// registers, prescaler, shared counter, channels
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  pwm_multi_if.slave     bus,
  output logic [NCH-1:0] pwm_out,
  output logic           irq
);

  ctrl_t          ctrl;
  logic [CW-1:0]  period_sh;
  logic [CW-1:0]  period_act;
  logic [CW-1:0]  counter;
  logic [CW-1:0]  cnt_nxt;
  logic [CW-1:0]  duty_sh [NCH];
  dir_t           dir;
  dir_t           dir_nxt;
  logic [15:0]    pre_count;
  logic [NCH-1:0] chen;
  logic [NCH-1:0] pol;
  logic [NCH-1:0] duty_sel;
  logic           wrap;
  logic           tick;
  logic           upd;
  logic           load_act;
  logic [31:0]    wd;

  logic hit_period, hit_ctrl, hit_counter;
  logic hit_status, hit_chen, hit_pol;

  wire unused = ^{bus.re, bus.write_data};

  assign wd = bus.write_data;

  assign hit_period  = bus.address == ADDR_PERIOD;
  assign hit_ctrl    = bus.address == ADDR_CTRL;
  assign hit_counter = bus.address == ADDR_COUNTER;
  assign hit_status  = bus.address == ADDR_STATUS;
  assign hit_chen    = bus.address == ADDR_CHEN;
  assign hit_pol     = bus.address == ADDR_POL;

  // one select per implemented duty register
  always_comb begin
    duty_sel = '0;
    for (int i = 0; i < NCH; i++)
      duty_sel[i] = bus.address == ADDR_DUTY + 8'(4 * i);
  end

  // read mux, unmapped addresses read zero
  always_comb begin
    bus.read_data = '0;
    unique case (1'b1)
      hit_period:  bus.read_data = 32'(period_sh);
      hit_ctrl:    bus.read_data = ctrl_word(ctrl);
      hit_counter: bus.read_data = 32'(counter);
      hit_status:  bus.read_data = {31'b0, wrap};
      hit_chen:    bus.read_data = 32'(chen);
      hit_pol:     bus.read_data = 32'(pol);
      default:     bus.read_data = '0;
    endcase
    for (int i = 0; i < NCH; i++)
      if (duty_sel[i])
        bus.read_data = 32'(duty_sh[i]);
  end

  // counter next state for edge and center alignment
  always_comb begin
    tick    = ctrl.enable && (pre_count == '0);
    upd     = 1'b0;
    cnt_nxt = counter;
    dir_nxt = dir;
    if (tick) begin
      if (period_act <= CW'(1)) begin
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
        upd     = 1'b1;
      end else if (!ctrl.center) begin
        if (counter >= period_act - CW'(1)) begin
          cnt_nxt = '0;
          upd     = 1'b1;
        end else begin
          cnt_nxt = counter + CW'(1);
        end
      end else if (dir == DIR_UP &&
                   counter < period_act - CW'(1)) begin
        cnt_nxt = counter + CW'(1);
      end else if (counter <= CW'(1)) begin
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
        upd     = 1'b1;
      end else begin
        cnt_nxt = counter - CW'(1);
        dir_nxt = DIR_DOWN;
      end
    end
  end

  assign load_act = upd || !ctrl.enable;
  assign irq      = wrap & ctrl.irqen;

  // control/status registers and active period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl       <= '{prescale: RST_PRESCALE,
                      irqen: 1'b0, center: 1'b0,
                      enable: 1'b0};
      period_sh  <= CW'(RST_PERIOD);
      period_act <= CW'(RST_PERIOD);
      chen       <= '0;
      pol        <= '0;
      wrap       <= 1'b0;
    end else begin
      if (bus.we && hit_ctrl)
        ctrl <= ctrl_t'({wd[CTRL_PRE_MSB:CTRL_PRE_LSB],
                         wd[CTRL_IRQEN], wd[CTRL_CENTER],
                         wd[CTRL_EN]});
      if (bus.we && hit_period)
        period_sh <= wd[CW-1:0];
      if (bus.we && hit_chen)
        chen <= wd[NCH-1:0];
      if (bus.we && hit_pol)
        pol <= wd[NCH-1:0];
      if (load_act)
        period_act <= period_sh;
      if (upd)
        wrap <= 1'b1;
      else if (bus.we && hit_status && wd[0])
        wrap <= 1'b0;
    end
  end

  // duty shadow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++)
        duty_sh[i] <= CW'(RST_DUTY);
    end else begin
      for (int i = 0; i < NCH; i++)
        if (bus.we && duty_sel[i])
          duty_sh[i] <= wd[CW-1:0];
    end
  end

  // counter, direction and prescaler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter   <= '0;
      dir       <= DIR_UP;
      pre_count <= '0;
    end else begin
      if (bus.we && hit_counter) begin
        counter <= '0;
        dir     <= DIR_UP;
      end else begin
        counter <= cnt_nxt;
        dir     <= dir_nxt;
      end
      if (bus.we && hit_ctrl)
        pre_count <= wd[CTRL_PRE_MSB:CTRL_PRE_LSB];
      else if (bus.we && hit_counter)
        pre_count <= ctrl.prescale;
      else if (ctrl.enable)
        pre_count <= tick ? ctrl.prescale
                          : pre_count - 16'd1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_multi_ch #(.CW(CW)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load_act),
      .duty_sh (duty_sh[i]),
      .counter (counter),
      .en      (ctrl.enable & chen[i]),
      .pol     (pol[i]),
      .pwm     (pwm_out[i])
    );
  end

endmodule
